// File: rtl/vga_pkg.sv
// Shared constants, colour palette, FSM encoding and config helpers for the VGA shape controller.
package vga_pkg;

  localparam int unsigned H_VALID = 640;
  localparam int unsigned V_VALID = 480;

  localparam logic [15:0] COLOUR_BLACK = 16'h0000;
  localparam logic [15:0] COLOUR_RED   = 16'hF800;
  localparam logic [15:0] COLOUR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOUR_BLUE  = 16'h001F;
  localparam logic [15:0] COLOUR_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StStepX,
    StStepY,
    StCommit
  } state_e;

  // Keeps a centre coordinate far enough from both edges that the whole circle fits.
  function automatic logic [9:0] clamp_axis(input logic [9:0] c, input logic [7:0] r,
                                            input logic [9:0] l);
    logic [9:0] lo;
    logic [9:0] hi;
    lo = {2'b00, r};
    hi = l - lo;
    if (c < lo) return lo;
    if (c > hi) return hi;
    return c;
  endfunction

  // -8 has no positive counterpart in 4 bits, so a bounce could not negate it.
  function automatic logic signed [3:0] sat_vel(input logic signed [3:0] v);
    return (v == 4'sb1000) ? 4'sb1001 : v;
  endfunction

endpackage

// File: rtl/vga_axis_step.sv
// One-axis bounce step: advance a coordinate by its velocity and reflect off [r, l-r].
module vga_axis_step (
  input  logic        [9:0] c_i,
  input  logic signed [3:0] v_i,
  input  logic        [7:0] r_i,
  input  logic        [9:0] l_i,
  output logic        [9:0] n_o,
  output logic signed [3:0] v_next_o,
  output logic              hit_o
);

  logic signed [10:0] sum;
  logic signed [10:0] lo;
  logic signed [10:0] hi;

  always_comb begin
    sum      = $signed({1'b0, c_i}) + $signed({{7{v_i[3]}}, v_i});
    lo       = $signed({3'b000, r_i});
    hi       = $signed({1'b0, l_i}) - lo;
    n_o      = sum[9:0];
    v_next_o = v_i;
    hit_o    = 1'b0;
    if (sum < lo) begin
      n_o      = lo[9:0];
      v_next_o = -v_i;
      hit_o    = 1'b1;
    end else if (sum > hi) begin
      n_o      = hi[9:0];
      v_next_o = -v_i;
      hit_o    = 1'b1;
    end
  end

endmodule

// File: rtl/vga_shape_ctrl.sv
// Per-frame circle controller: buffers one host config and applies it, or bounces the centre,
// in a short FSM sequence launched by frame_start so outputs only change in vertical blanking.
module vga_shape_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned RADIUS_MAX = 100
) (
  input  logic               Clk_int_i,
  input  logic               Sys_Rst_i,
  input  logic               frame_start_i,
  input  logic               run_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic        [9:0]  cfg_cx_i,
  input  logic        [9:0]  cfg_cy_i,
  input  logic        [7:0]  cfg_r_i,
  input  logic signed [3:0]  cfg_vx_i,
  input  logic signed [3:0]  cfg_vy_i,
  input  logic        [15:0] cfg_colour_i,
  output logic        [9:0]  shape_cx_o,
  output logic        [9:0]  shape_cy_o,
  output logic        [7:0]  shape_r_o,
  output logic        [15:0] shape_colour_o,
  output logic               shape_vld_o,
  output logic               edge_hit_o
);

  state_e             state_q;
  logic        [9:0]  shape_cx_q, shape_cy_q;
  logic        [7:0]  shape_r_q;
  logic        [15:0] shape_colour_q;
  logic signed [3:0]  vx_q, vy_q;
  logic               vld_q, edge_hit_q;

  logic               pend_q, use_pend_q, run_q;
  logic        [9:0]  pend_cx_q, pend_cy_q;
  logic        [7:0]  pend_r_q;
  logic signed [3:0]  pend_vx_q, pend_vy_q;
  logic        [15:0] pend_colour_q;

  logic        [9:0]  nx_q, ny_q;
  logic signed [3:0]  nvx_q, nvy_q;
  logic               hitx_q, hity_q;

  logic        [7:0]  r_lim;
  logic        [7:0]  pend_r_d;
  logic        [9:0]  pend_cx_d, pend_cy_d;
  logic               cfg_accept;

  logic        [9:0]  step_c, step_l, step_n;
  logic signed [3:0]  step_v, step_v_next;
  logic               step_hit;

  always_comb begin
    r_lim      = (cfg_r_i > 8'(RADIUS_MAX)) ? 8'(RADIUS_MAX) : cfg_r_i;
    pend_r_d   = (r_lim == 8'd0) ? 8'd1 : r_lim;
    pend_cx_d  = clamp_axis(cfg_cx_i, pend_r_d, 10'(H_VALID - 1));
    pend_cy_d  = clamp_axis(cfg_cy_i, pend_r_d, 10'(V_VALID - 1));
    cfg_accept = cfg_valid_i && !pend_q;
  end

  // The single step unit sees X operands except while the FSM is in StStepY.
  always_comb begin
    step_c = shape_cx_q;
    step_v = vx_q;
    step_l = 10'(H_VALID - 1);
    if (state_q == StStepY) begin
      step_c = shape_cy_q;
      step_v = vy_q;
      step_l = 10'(V_VALID - 1);
    end
  end

  vga_axis_step u_axis_step (
    .c_i      (step_c),
    .v_i      (step_v),
    .r_i      (shape_r_q),
    .l_i      (step_l),
    .n_o      (step_n),
    .v_next_o (step_v_next),
    .hit_o    (step_hit)
  );

  always_ff @(posedge Clk_int_i) begin
    if (Sys_Rst_i) begin
      state_q        <= StIdle;
      shape_cx_q     <= 10'd320;
      shape_cy_q     <= 10'd240;
      shape_r_q      <= 8'd40;
      shape_colour_q <= COLOUR_RED;
      vx_q           <= 4'sd2;
      vy_q           <= 4'sd1;
      vld_q          <= 1'b0;
      edge_hit_q     <= 1'b0;
      pend_q         <= 1'b0;
      use_pend_q     <= 1'b0;
      run_q          <= 1'b0;
      pend_cx_q      <= '0;
      pend_cy_q      <= '0;
      pend_r_q       <= '0;
      pend_vx_q      <= '0;
      pend_vy_q      <= '0;
      pend_colour_q  <= '0;
      nx_q           <= '0;
      ny_q           <= '0;
      nvx_q          <= '0;
      nvy_q          <= '0;
      hitx_q         <= 1'b0;
      hity_q         <= 1'b0;
    end else begin
      edge_hit_q <= 1'b0;
      if (cfg_accept) begin
        pend_q        <= 1'b1;
        pend_cx_q     <= pend_cx_d;
        pend_cy_q     <= pend_cy_d;
        pend_r_q      <= pend_r_d;
        pend_vx_q     <= sat_vel(cfg_vx_i);
        pend_vy_q     <= sat_vel(cfg_vy_i);
        pend_colour_q <= cfg_colour_i;
      end
      unique case (state_q)
        StIdle: begin
          if (frame_start_i) begin
            // Sampled before any same-cycle capture lands, so such a config waits a frame.
            use_pend_q <= pend_q;
            run_q      <= run_i;
            state_q    <= StStepX;
          end
        end
        StStepX: begin
          hitx_q  <= 1'b0;
          nx_q    <= shape_cx_q;
          nvx_q   <= vx_q;
          state_q <= StStepY;
          if (use_pend_q) begin
            nx_q  <= pend_cx_q;
            nvx_q <= pend_vx_q;
          end else if (run_q) begin
            nx_q   <= step_n;
            nvx_q  <= step_v_next;
            hitx_q <= step_hit;
          end
        end
        StStepY: begin
          hity_q  <= 1'b0;
          ny_q    <= shape_cy_q;
          nvy_q   <= vy_q;
          state_q <= StCommit;
          if (use_pend_q) begin
            ny_q  <= pend_cy_q;
            nvy_q <= pend_vy_q;
          end else if (run_q) begin
            ny_q   <= step_n;
            nvy_q  <= step_v_next;
            hity_q <= step_hit;
          end
        end
        StCommit: begin
          shape_cx_q <= nx_q;
          shape_cy_q <= ny_q;
          vx_q       <= nvx_q;
          vy_q       <= nvy_q;
          vld_q      <= 1'b1;
          edge_hit_q <= hitx_q | hity_q;
          if (use_pend_q) begin
            shape_r_q      <= pend_r_q;
            shape_colour_q <= pend_colour_q;
            pend_q         <= 1'b0;
          end
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cfg_ready_o    = !pend_q;
  assign shape_cx_o     = shape_cx_q;
  assign shape_cy_o     = shape_cy_q;
  assign shape_r_o      = shape_r_q;
  assign shape_colour_o = shape_colour_q;
  assign shape_vld_o    = vld_q;
  assign edge_hit_o     = edge_hit_q;

endmodule

// File: tb/tb_vga_shape_ctrl.sv
// Directed bench for vga_shape_ctrl: table of config/frame vectors plus handshake and reset cases.
module tb_vga_shape_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_start = 1'b0;
  logic               run = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic        [9:0]  cfg_cx = '0;
  logic        [9:0]  cfg_cy = '0;
  logic        [7:0]  cfg_r = '0;
  logic signed [3:0]  cfg_vx = '0;
  logic signed [3:0]  cfg_vy = '0;
  logic        [15:0] cfg_colour = '0;
  logic        [9:0]  shape_cx, shape_cy;
  logic        [7:0]  shape_r;
  logic        [15:0] shape_colour;
  logic               shape_vld, edge_hit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_shape_ctrl dut (
    .Clk_int_i      (clk),
    .Sys_Rst_i      (rst),
    .frame_start_i  (frame_start),
    .run_i          (run),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_cx_i       (cfg_cx),
    .cfg_cy_i       (cfg_cy),
    .cfg_r_i        (cfg_r),
    .cfg_vx_i       (cfg_vx),
    .cfg_vy_i       (cfg_vy),
    .cfg_colour_i   (cfg_colour),
    .shape_cx_o     (shape_cx),
    .shape_cy_o     (shape_cy),
    .shape_r_o      (shape_r),
    .shape_colour_o (shape_colour),
    .shape_vld_o    (shape_vld),
    .edge_hit_o     (edge_hit)
  );

  typedef struct {
    bit                do_cfg;
    logic        [9:0] cx;
    logic        [9:0] cy;
    logic        [7:0] r;
    logic signed [3:0] vx;
    logic signed [3:0] vy;
    logic       [15:0] col;
    bit                run;
    logic        [9:0] e_cx;
    logic        [9:0] e_cy;
    logic        [7:0] e_r;
    logic       [15:0] e_col;
    bit                e_hit;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [9:0] cx, input logic [9:0] cy, input logic [7:0] r,
                         input logic signed [3:0] vx, input logic signed [3:0] vy,
                         input logic [15:0] col);
    cfg_valid  = 1'b1;
    cfg_cx     = cx;
    cfg_cy     = cy;
    cfg_r      = r;
    cfg_vx     = vx;
    cfg_vy     = vy;
    cfg_colour = col;
  endtask

  // Pulses frame_start and returns just after edge t+2, one edge before the commit.
  task automatic frame_to_step_y(input bit run_v);
    frame_start = 1'b1;
    run         = run_v;
    tick();
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_shape(input string tag, input logic [9:0] cx, input logic [9:0] cy,
                           input logic [7:0] r, input logic [15:0] col);
    chk({tag, "_cx"}, 32'(shape_cx), 32'(cx));
    chk({tag, "_cy"}, 32'(shape_cy), 32'(cy));
    chk({tag, "_r"}, 32'(shape_r), 32'(r));
    chk({tag, "_colour"}, 32'(shape_colour), 32'(col));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] prev_cx;

    //              cfg cx      cy      r      vx       vy      col       run  e_cx    e_cy    e_r    e_col     hit
    vecs[0]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd322, 10'd241, 8'd40,  16'hF800, 1'b0};
    vecs[1]  = '{1'b1, 10'd597,  10'd240,  8'd40,  4'sd5,   4'sd0, 16'h07E0, 1'b1, 10'd597, 10'd240, 8'd40,  16'h07E0, 1'b0};
    vecs[2]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd599, 10'd240, 8'd40,  16'h07E0, 1'b1};
    vecs[3]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd594, 10'd240, 8'd40,  16'h07E0, 1'b0};
    vecs[4]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b0, 10'd594, 10'd240, 8'd40,  16'h07E0, 1'b0};
    vecs[5]  = '{1'b1, 10'd50,   10'd470,  8'd200, 4'sb1000, 4'sd3, 16'h001F, 1'b1, 10'd100, 10'd379, 8'd100, 16'h001F, 1'b0};
    vecs[6]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd100, 10'd379, 8'd100, 16'h001F, 1'b1};
    vecs[7]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd107, 10'd376, 8'd100, 16'h001F, 1'b0};
    vecs[8]  = '{1'b1, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'hFFFF, 1'b1, 10'd1,   10'd1,   8'd1,   16'hFFFF, 1'b0};
    vecs[9]  = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd1,   10'd1,   8'd1,   16'hFFFF, 1'b0};
    vecs[10] = '{1'b1, 10'd1023, 10'd1023, 8'd10,  4'sd7,   4'sd7, 16'h0000, 1'b1, 10'd629, 10'd469, 8'd10,  16'h0000, 1'b0};
    vecs[11] = '{1'b0, 10'd0,    10'd0,    8'd0,   4'sd0,   4'sd0, 16'h0000, 1'b1, 10'd629, 10'd469, 8'd10,  16'h0000, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_shape("reset", 10'd320, 10'd240, 8'd40, 16'hF800);
    chk("reset_vld", 32'(shape_vld), 32'd0);
    chk("reset_edge_hit", 32'(edge_hit), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();

    prev_cx = 10'd320;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_cfg) begin
        set_cfg(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].vx, vecs[i].vy, vecs[i].col);
        tick();
        cfg_valid = 1'b0;
        chk($sformatf("v%0d_cfg_ready_fall", i), 32'(cfg_ready), 32'd0);
      end
      frame_to_step_y(vecs[i].run);
      chk($sformatf("v%0d_hold_before_commit", i), 32'(shape_cx), 32'(prev_cx));
      tick();
      chk_shape($sformatf("v%0d", i), vecs[i].e_cx, vecs[i].e_cy, vecs[i].e_r, vecs[i].e_col);
      chk($sformatf("v%0d_vld", i), 32'(shape_vld), 32'd1);
      chk($sformatf("v%0d_edge_hit", i), 32'(edge_hit), 32'(vecs[i].e_hit));
      tick();
      chk($sformatf("v%0d_edge_hit_clear", i), 32'(edge_hit), 32'd0);
      chk($sformatf("v%0d_cfg_ready", i), 32'(cfg_ready), 32'd1);
      prev_cx = vecs[i].e_cx;
      tick();
    end

    // Second offer while one config is outstanding must be held off.
    set_cfg(10'd300, 10'd200, 8'd20, 4'sd1, 4'sd1, 16'h07E0);
    tick();
    set_cfg(10'd400, 10'd100, 8'd30, 4'sd2, 4'sd2, 16'h001F);
    tick();
    chk("busy_ready0_a", 32'(cfg_ready), 32'd0);
    tick();
    chk("busy_ready0_b", 32'(cfg_ready), 32'd0);
    frame_start = 1'b1;
    run         = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    chk("busy_ready0_t2", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    tick();
    chk_shape("busy_commit", 10'd300, 10'd200, 8'd20, 16'h07E0);
    tick();
    chk("busy_ready_t4", 32'(cfg_ready), 32'd1);
    tick();
    frame_to_step_y(1'b0);
    tick();
    chk_shape("busy_no_second", 10'd300, 10'd200, 8'd20, 16'h07E0);
    tick();
    tick();

    // Accept coincident with frame_start: motion now, config on the following frame.
    set_cfg(10'd100, 10'd100, 8'd50, 4'sd2, 4'sd2, 16'hFFFF);
    frame_to_step_y(1'b1);
    chk("same_ready0", 32'(cfg_ready), 32'd0);
    tick();
    chk_shape("same_motion", 10'd301, 10'd201, 8'd20, 16'h07E0);
    tick();
    chk("same_still_pending", 32'(cfg_ready), 32'd0);
    tick();
    frame_to_step_y(1'b1);
    tick();
    chk_shape("same_applied", 10'd100, 10'd100, 8'd50, 16'hFFFF);
    tick();
    chk("same_ready1", 32'(cfg_ready), 32'd1);
    tick();

    // Reset during StStepY with a config pending.
    set_cfg(10'd500, 10'd400, 8'd30, 4'sd3, 4'sd3, 16'h001F);
    frame_start = 1'b1;
    run         = 1'b1;
    tick();
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_shape("midrst", 10'd320, 10'd240, 8'd40, 16'hF800);
    chk("midrst_vld", 32'(shape_vld), 32'd0);
    chk("midrst_edge_hit", 32'(edge_hit), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    tick();
    tick();
    frame_to_step_y(1'b1);
    tick();
    chk_shape("midrst_move", 10'd322, 10'd241, 8'd40, 16'hF800);
    chk("midrst_move_vld", 32'(shape_vld), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
